// File: rtl/pixie_pkg.sv
// Shared types and constants for the Pixie display DMA responder.
package pixie_pkg;

    // Burst sequencer states: wait for DMAO, present address, capture byte, close line.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        LINE = 2'd3
    } dma_state_t;

    // Studio II display window defaults.
    localparam logic [11:0] VRAM_BASE   = 12'h900;
    localparam int          DISP_BYTES  = 8;
    localparam int          DISP_REPEAT = 4;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pixie_ptr_ctrl.sv
// Emulated R0 display pointer, line repetition and frame reload bookkeeping.
module pixie_ptr_ctrl
    import pixie_pkg::*;
#(
    parameter int            AW             = 12,
    parameter int            BYTES_PER_LINE = DISP_BYTES,
    parameter int            LINE_REPEAT    = DISP_REPEAT,
    parameter logic [AW-1:0] RESET_BASE     = AW'(VRAM_BASE)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] disp_base,
    input  logic          frame_int,
    input  logic          in_idle,
    input  logic          byte_step,
    input  logic          line_end,
    output logic [AW-1:0] ptr,
    output logic [7:0]    line_cnt
);

    localparam logic [AW-1:0] STEP     = AW'(BYTES_PER_LINE);
    localparam logic [7:0]    REP_LAST = 8'(LINE_REPEAT - 1);

    logic [7:0] rep_cnt;
    logic       pending;
    logic       reload;

    // A frame start reloads at once when idle; mid-burst it is deferred to the
    // end of the line so the current line still reads from the old pointer.
    assign reload = (in_idle & frame_int) | (line_end & (pending | frame_int));

    // Pointer / repeat / line counters; a reload overrides the line rewind.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ptr      <= RESET_BASE;
            rep_cnt  <= 8'd0;
            line_cnt <= 8'd0;
            pending  <= 1'b0;
        end else if (reload) begin
            ptr      <= disp_base;
            rep_cnt  <= 8'd0;
            line_cnt <= 8'd0;
            pending  <= 1'b0;
        end else begin
            // Only reachable in ADDR/DATA: remember the frame start for later.
            if (frame_int)
                pending <= 1'b1;
            if (byte_step)
                ptr <= ptr + AW'(1);
            if (line_end) begin
                line_cnt <= sat_inc8(line_cnt);
                if (rep_cnt < REP_LAST) begin
                    // Replay the same row of display data on the next scan line.
                    ptr     <= ptr - STEP;
                    rep_cnt <= rep_cnt + 8'd1;
                end else begin
                    rep_cnt <= 8'd0;
                end
            end
        end
    end

endmodule

// File: rtl/pixie_dma_responder.sv
// Answers Pixie DMAO with a CDP1802-style DMA-out byte burst from VRAM,
// stalling the CPU for the duration of each burst.
module pixie_dma_responder
    import pixie_pkg::*;
#(
    parameter int            AW             = 12,
    parameter int            BYTES_PER_LINE = DISP_BYTES,
    parameter int            LINE_REPEAT    = DISP_REPEAT,
    parameter logic [AW-1:0] RESET_BASE     = AW'(VRAM_BASE)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          disp_en,
    input  logic [AW-1:0] disp_base,
    input  logic          frame_int,
    input  logic          dma_req,
    output logic [AW-1:0] vram_addr,
    output logic          vram_rd,
    input  logic [7:0]    vram_q,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    output logic          cpu_wait,
    output logic          busy,
    output logic [7:0]    line_cnt
);

    localparam int BCW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

    dma_state_t     state, state_nxt;
    logic           dma_req_d;
    logic           start_held;
    logic           start;
    logic           go;
    logic [BCW-1:0] byte_cnt;
    logic           last_byte;
    logic           in_idle;
    logic           byte_step;
    logic           line_end;
    logic [AW-1:0]  ptr;

    // A start that collides with a frame reload is parked for one cycle so the
    // burst begins from the freshly loaded base rather than being lost.
    assign start     = dma_req & ~dma_req_d & disp_en;
    assign go        = start | start_held;
    assign last_byte = (byte_cnt == BCW'(BYTES_PER_LINE - 1));

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: ADDR/DATA alternate per byte, LINE closes the burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go && !frame_int) state_nxt = ADDR;
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = last_byte ? LINE : ADDR;
            LINE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State decode for the read strobe and the pointer controller.
    always_comb begin
        vram_rd   = 1'b0;
        in_idle   = 1'b0;
        byte_step = 1'b0;
        line_end  = 1'b0;
        case (state)
            IDLE:    in_idle   = 1'b1;
            ADDR:    vram_rd   = 1'b1;
            DATA:    byte_step = 1'b1;
            LINE:    line_end  = 1'b1;
            default: in_idle   = 1'b1;
        endcase
    end

    assign busy      = ~in_idle;
    assign vram_addr = ptr;

    // Edge register, byte counter, registered pixel output and CPU stall.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dma_req_d  <= 1'b0;
            start_held <= 1'b0;
            byte_cnt   <= '0;
            pix_data   <= 8'd0;
            pix_valid  <= 1'b0;
            cpu_wait   <= 1'b0;
        end else begin
            dma_req_d <= dma_req;
            pix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_int) begin
                        start_held <= go;
                    end else if (go) begin
                        start_held <= 1'b0;
                        byte_cnt   <= '0;
                        cpu_wait   <= 1'b1;
                    end
                end
                DATA: begin
                    // RAM output is valid here, one clock after the address.
                    pix_data  <= vram_q;
                    pix_valid <= 1'b1;
                    byte_cnt  <= byte_cnt + BCW'(1);
                end
                LINE:    cpu_wait <= 1'b0;
                default: ;
            endcase
        end
    end

    pixie_ptr_ctrl #(
        .AW             (AW),
        .BYTES_PER_LINE (BYTES_PER_LINE),
        .LINE_REPEAT    (LINE_REPEAT),
        .RESET_BASE     (RESET_BASE)
    ) u_ptr (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .disp_base (disp_base),
        .frame_int (frame_int),
        .in_idle   (in_idle),
        .byte_step (byte_step),
        .line_end  (line_end),
        .ptr       (ptr),
        .line_cnt  (line_cnt)
    );

endmodule

// File: tb/tb_pixie_dma_responder.sv
// Directed bench for pixie_dma_responder: default instance plus a
// LINE_REPEAT=1 instance sharing the same stimulus.
module tb_pixie_dma_responder;

    logic        clk_sys = 1'b0;
    logic        reset, disp_en, frame_int, dma_req;
    logic [11:0] disp_base;

    logic [11:0] vram_addr0, vram_addr1;
    logic        vram_rd0, vram_rd1;
    logic [7:0]  vram_q0, vram_q1;
    logic [7:0]  pix_data0, pix_data1;
    logic        pix_valid0, pix_valid1;
    logic        cpu_wait0, cpu_wait1;
    logic        busy0, busy1;
    logic [7:0]  line_cnt0, line_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    pixie_dma_responder u_dut0 (
        .clk_sys(clk_sys), .reset(reset), .disp_en(disp_en), .disp_base(disp_base),
        .frame_int(frame_int), .dma_req(dma_req), .vram_addr(vram_addr0),
        .vram_rd(vram_rd0), .vram_q(vram_q0), .pix_data(pix_data0),
        .pix_valid(pix_valid0), .cpu_wait(cpu_wait0), .busy(busy0),
        .line_cnt(line_cnt0)
    );

    pixie_dma_responder #(.LINE_REPEAT(1)) u_dut1 (
        .clk_sys(clk_sys), .reset(reset), .disp_en(disp_en), .disp_base(disp_base),
        .frame_int(frame_int), .dma_req(dma_req), .vram_addr(vram_addr1),
        .vram_rd(vram_rd1), .vram_q(vram_q1), .pix_data(pix_data1),
        .pix_valid(pix_valid1), .cpu_wait(cpu_wait1), .busy(busy1),
        .line_cnt(line_cnt1)
    );

    // VRAM contents: a fixed scramble of the address.
    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    // Synchronous-read RAM: data one clock after the address.
    always @(posedge clk_sys) begin
        vram_q0 <= mem_byte(vram_addr0);
        vram_q1 <= mem_byte(vram_addr1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic frame_pulse(input logic [11:0] base);
        disp_base = base;
        frame_int = 1'b1;
        tick();
        frame_int = 1'b0;
    endtask

    // One DMAO burst observed on instance sel. off = extra start latency,
    // fi_at = cycle frame_int is driven, drop_at = cycle dma_req falls.
    task automatic run_burst(input int sel, input logic [11:0] base, input int off,
                             input int fi_at, input int drop_at);
        int          n_rd, n_pv, n_wait;
        logic [11:0] a;
        logic        o_rd, o_pv, o_wt;
        logic [11:0] o_addr;
        logic [7:0]  o_dat;
        n_rd = 0; n_pv = 0; n_wait = 0;
        dma_req = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            frame_int = (c == fi_at);
            if (c == drop_at) dma_req = 1'b0;
            tick();
            o_rd   = sel ? vram_rd1   : vram_rd0;
            o_pv   = sel ? pix_valid1 : pix_valid0;
            o_wt   = sel ? cpu_wait1  : cpu_wait0;
            o_addr = sel ? vram_addr1 : vram_addr0;
            o_dat  = sel ? pix_data1  : pix_data0;
            if (o_wt) n_wait++;
            if (o_rd) begin
                a = base + 12'(n_rd);
                chk("rd_addr", 32'(o_addr), 32'(a));
                chk("rd_cycle", c, 1 + off + 2 * n_rd);
                n_rd++;
            end
            if (o_pv) begin
                a = base + 12'(n_pv);
                chk("pix_data", 32'(o_dat), 32'(mem_byte(a)));
                chk("pix_cycle", c, 3 + off + 2 * n_pv);
                n_pv++;
            end
        end
        frame_int = 1'b0;
        dma_req   = 1'b0;
        tick();
        chk("rd_count", n_rd, 8);
        chk("valid_count", n_pv, 8);
        chk("wait_cycles", n_wait, 17);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        reset = 1'b1; disp_en = 1'b1; frame_int = 1'b0; dma_req = 1'b0;
        disp_base = 12'h000;
        tick(); tick();
        chk("rst_addr", 32'(vram_addr0), 32'h900);
        chk("rst_rd", 32'(vram_rd0), 0);
        chk("rst_valid", 32'(pix_valid0), 0);
        chk("rst_data", 32'(pix_data0), 0);
        chk("rst_wait", 32'(cpu_wait0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_line", 32'(line_cnt0), 0);
        reset = 1'b0;
        tick();

        // Basic burst, then line repetition over five bursts.
        frame_pulse(12'h900);
        run_burst(0, 12'h900, 0, -1, -1);
        chk("line_after_1", 32'(line_cnt0), 1);
        run_burst(0, 12'h900, 0, -1, -1);
        run_burst(0, 12'h900, 0, -1, 4);   // dma_req drops mid-burst
        run_burst(0, 12'h900, 0, -1, -1);
        run_burst(0, 12'h908, 0, -1, -1);
        chk("line_after_5", 32'(line_cnt0), 5);

        // Frame start during a burst: finish on old pointer, reload after.
        frame_pulse(12'h900);
        disp_base = 12'hA00;
        run_burst(0, 12'h900, 0, 8, -1);
        chk("reload_line", 32'(line_cnt0), 0);
        chk("reload_ptr", 32'(vram_addr0), 32'hA00);
        for (int k = 0; k < 4; k++) run_burst(0, 12'hA00, 0, -1, -1);
        run_burst(0, 12'hA08, 0, -1, -1);
        chk("reload_line5", 32'(line_cnt0), 5);

        // Display disabled: DMAO edges ignored.
        disp_en = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            dma_req = 1'b1;
            for (int j = 0; j < 4; j++) begin
                tick();
                if (vram_rd0 || pix_valid0 || cpu_wait0 || busy0) bad++;
                if (j == 1) dma_req = 1'b0;
            end
        end
        chk("disp_off_activity", bad, 0);
        disp_en = 1'b1;
        tick();

        // Frame start and DMAO edge together: reload wins, burst one clock later.
        disp_base = 12'hB00;
        run_burst(0, 12'hB00, 1, 1, -1);

        // Wrap upward (LINE_REPEAT=1) and downward rewind (default instance).
        frame_pulse(12'hFFC);
        run_burst(1, 12'hFFC, 0, -1, -1);
        chk("wrap_up_ptr", 32'(vram_addr1), 32'h004);
        chk("wrap_down_ptr", 32'(vram_addr0), 32'hFFC);

        // Reset mid-burst during DATA of the third byte.
        frame_pulse(12'hC00);
        dma_req = 1'b1;
        for (int j = 0; j < 6; j++) tick();
        chk("pre_rst_busy", 32'(busy0), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_wait", 32'(cpu_wait0), 0);
        chk("mid_rst_ptr", 32'(vram_addr0), 32'h900);
        chk("mid_rst_valid", 32'(pix_valid0), 0);
        reset = 1'b0;
        dma_req = 1'b0;
        tick();
        run_burst(0, 12'h900, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
